// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART widths used by receiver, transmitter and FIFO
package uart_pkg;

    localparam int UART_DBIT        = 8;
    localparam int UART_FIFO_ADDR_W = 4;

endpackage

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - FIFO storage: synchronous write, asynchronous read, no reset
module uart_fifo_ram #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DBIT-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DBIT-1:0]   rdata
);

    logic [DBIT-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO with FWFT read port, level/almost-full and sticky overrun
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT     = UART_DBIT,
    parameter int ADDR_W   = UART_FIFO_ADDR_W,
    parameter int AF_LEVEL = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [DBIT-1:0]   din,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DBIT-1:0]   rd_data,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] AF_L    = (ADDR_W+1)'(AF_LEVEL);

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            overrun_q, overrun_d;
    logic [ADDR_W:0] level_w;
    logic            empty_w, full_w;
    logic            pop, push, drop;
    logic [DBIT-1:0] ram_rdata;

    // Pointers carry one extra bit so full and empty stay distinguishable.
    always_comb begin
        level_w   = wr_ptr_q - rd_ptr_q;
        empty_w   = (level_w == '0);
        full_w    = (level_w == DEPTH_L);
        pop       = ~empty_w & rd_ready;
        push      = rx_done_tick & (~full_w | pop);
        drop      = rx_done_tick & full_w & ~pop;
        wr_ptr_d  = wr_ptr_q + (ADDR_W+1)'(push);
        rd_ptr_d  = rd_ptr_q + (ADDR_W+1)'(pop);
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    uart_fifo_ram #(
        .DBIT   (DBIT),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (din),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    assign rd_valid    = ~empty_w;
    assign rd_data     = empty_w ? '0 : ram_rdata;
    assign level       = level_w;
    assign full        = full_w;
    assign empty       = empty_w;
    assign almost_full = (level_w >= AF_L);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - vector table, directed corner cases and random run against a queue model
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] din;
    logic       rd_ready;
    logic       clr_overrun;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [4:0] level;
    logic       full, empty, almost_full, overrun;

    int errors = 0;
    int checks = 0;

    logic [7:0] mq[$];
    logic       m_ovr;

    typedef struct {
        logic       rx;
        logic [7:0] din;
        logic       rdy;
        logic       clr;
        int         lvl;
        logic       vld;
        logic [7:0] data;
        logic       full;
        logic       af;
        logic       ovr;
    } vec_t;

    vec_t tbl[6];

    uart_rx_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .din          (din),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, " level"}, int'(level), n);
        chk({tag, " rd_valid"}, int'(rd_valid), int'(n != 0));
        chk({tag, " empty"}, int'(empty), int'(n == 0));
        chk({tag, " full"}, int'(full), int'(n == 16));
        chk({tag, " almost_full"}, int'(almost_full), int'(n >= 12));
        chk({tag, " rd_data"}, int'(rd_data), (n != 0) ? int'(mq[0]) : 0);
        chk({tag, " overrun"}, int'(overrun), int'(m_ovr));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rst level"}, int'(level), 0);
        chk({tag, " rst empty"}, int'(empty), 1);
        chk({tag, " rst rd_valid"}, int'(rd_valid), 0);
        chk({tag, " rst rd_data"}, int'(rd_data), 0);
        chk({tag, " rst full"}, int'(full), 0);
        chk({tag, " rst almost_full"}, int'(almost_full), 0);
        chk({tag, " rst overrun"}, int'(overrun), 0);
    endtask

    // Called at a falling edge; drives inputs, advances one rising edge, checks at next falling edge.
    task automatic cycle(input logic rx, input logic [7:0] d, input logic rdy, input logic clr,
                         input string tag);
        bit m_pop, m_push, m_drop;
        rx_done_tick = rx;
        din          = d;
        rd_ready     = rdy;
        clr_overrun  = clr;
        m_pop  = (mq.size() != 0) && rdy;
        m_push = rx && ((mq.size() < 16) || m_pop);
        m_drop = rx && (mq.size() == 16) && !m_pop;
        @(posedge clk);
        if (m_pop)  void'(mq.pop_front());
        if (m_push) mq.push_back(d);
        if (m_drop) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        @(negedge clk);
        rx_done_tick = 1'b0;
        rd_ready     = 1'b0;
        clr_overrun  = 1'b0;
        chk_model(tag);
    endtask

    task automatic do_reset(input string tag);
        rx_done_tick = 1'b0;
        rd_ready     = 1'b0;
        clr_overrun  = 1'b0;
        din          = 8'h00;
        #2 reset = 1'b1;
        #1 chk_reset_vals(tag);
        mq.delete();
        m_ovr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 2, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 3, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'h44, 1'b1, 1'b0, 2, 1'b1, 8'h43, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 2, 1'b1, 8'h43, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        rx_done_tick = 1'b0;
        rd_ready = 1'b0;
        clr_overrun = 1'b0;
        din = 8'h00;
        m_ovr = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("init");
        reset = 1'b0;

        // Table vectors: basic pushes, pop, push+pop
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].rx, tbl[i].din, tbl[i].rdy, tbl[i].clr, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d level", i), int'(level), tbl[i].lvl);
            chk($sformatf("vec%0d rd_valid", i), int'(rd_valid), int'(tbl[i].vld));
            chk($sformatf("vec%0d rd_data", i), int'(rd_data), int'(tbl[i].data));
            chk($sformatf("vec%0d full", i), int'(full), int'(tbl[i].full));
            chk($sformatf("vec%0d almost_full", i), int'(almost_full), int'(tbl[i].af));
            chk($sformatf("vec%0d overrun", i), int'(overrun), int'(tbl[i].ovr));
        end

        // Fill, overflow, drain in order
        do_reset("t2");
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0, "t2 fill");
            chk("t2 af threshold", int'(almost_full), int'(i + 1 >= 12));
        end
        chk("t2 full", int'(full), 1);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, "t2 overflow");
        chk("t2 overrun set", int'(overrun), 1);
        chk("t2 level 16", int'(level), 16);
        for (int i = 0; i < 16; i++) begin
            chk("t2 drain order", int'(rd_data), i);
            cycle(1'b0, 8'h00, 1'b1, 1'b0, "t2 drain");
        end
        chk("t2 empty", int'(empty), 1);
        chk("t2 rd_data zero", int'(rd_data), 0);

        // Push+pop on a full FIFO
        do_reset("t3");
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, "t3 fill");
        cycle(1'b1, 8'hAA, 1'b1, 1'b0, "t3 pushpop");
        chk("t3 level 16", int'(level), 16);
        chk("t3 no overrun", int'(overrun), 0);
        for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "t3 drain");
        chk("t3 last AA", int'(rd_data), 8'hAA);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "t3 drain last");

        // No empty bypass
        cycle(1'b1, 8'h55, 1'b1, 1'b0, "t4 push");
        chk("t4 valid after push", int'(rd_valid), 1);
        chk("t4 data 55", int'(rd_data), 8'h55);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "t4 pop");
        chk("t4 empty again", int'(empty), 1);

        // Overrun set beats clear
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i + 8'h30), 1'b0, 1'b0, "t5 fill");
        cycle(1'b1, 8'h99, 1'b0, 1'b0, "t5 ovf");
        chk("t5 overrun", int'(overrun), 1);
        cycle(1'b1, 8'h98, 1'b0, 1'b1, "t5 ovf+clr");
        chk("t5 set beats clr", int'(overrun), 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, "t5 clr");
        chk("t5 cleared", int'(overrun), 0);

        // Random interleave wrapping pointers, async reset mid-stream
        do_reset("t6");
        for (int i = 0; i < 160; i++)
            cycle($urandom_range(0, 99) < 70, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 5, "t6a");
        rx_done_tick = 1'b1;
        rd_ready = 1'b1;
        #2 reset = 1'b1;
        #1 chk_reset_vals("t6 mid");
        mq.delete();
        m_ovr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        rx_done_tick = 1'b0;
        rd_ready = 1'b0;
        for (int i = 0; i < 80; i++)
            cycle($urandom_range(0, 99) < 60, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 5, "t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
